// File: rtl/datamem_arb_pkg.sv
// rtl/datamem_arb_pkg.sv - shared types and constants for the data memory arbiter
package datamem_arb_pkg;

  localparam int NUM_REQ    = 2;
  localparam int CMD_ADDR_W = 32;

  typedef logic req_id_t;

  // Address is carried at full width; the arbiter trims it to the memory's byte-address width.
  typedef struct packed {
    logic [CMD_ADDR_W-1:0] addr;
    logic [31:0]           wdata;
    logic [3:0]            mask;
    logic                  we;
  } dm_cmd_t;

endpackage

// File: rtl/datamem_arbiter_tag_fifo.sv
// rtl/datamem_arbiter_tag_fifo.sv - read-tag FIFO recording which requester owns each outstanding read
module arb_tag_fifo
  import datamem_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    push,
  input  req_id_t push_id,
  input  logic    pop,
  output logic    full,
  output logic    empty,
  output req_id_t head
);

  localparam int PW = $clog2(DEPTH);

  req_id_t         mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW:0]     count;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  // Tag storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

  // Pointers and occupancy; simultaneous push and pop leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - two-requester data memory arbiter (DATAMEM_ARB_FIXED_PRIO_EN selects fixed priority)
module datamem_arbiter
  import datamem_arb_pkg::*;
#(
  parameter  int DATAMEM_DEPTH   = 8192,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int AW              = $clog2(DATAMEM_DEPTH) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_cmd_valid,
  output logic          m0_cmd_ready,
  input  logic [AW-1:0] m0_cmd_addr,
  input  logic [31:0]   m0_cmd_wdata,
  input  logic [3:0]    m0_cmd_mask,
  input  logic          m0_cmd_we,
  output logic [31:0]   m0_rsp_data,
  output logic          m0_rsp_valid,
  input  logic          m1_cmd_valid,
  output logic          m1_cmd_ready,
  input  logic [AW-1:0] m1_cmd_addr,
  input  logic [31:0]   m1_cmd_wdata,
  input  logic [3:0]    m1_cmd_mask,
  input  logic          m1_cmd_we,
  output logic [31:0]   m1_rsp_data,
  output logic          m1_rsp_valid,
  output logic [AW-1:0] datamem_addr,
  output logic [31:0]   datamem_wdata,
  output logic [3:0]    datamem_mask,
  output logic          datamem_we,
  output logic          datamem_valid,
  input  logic          datamem_ready,
  input  logic [31:0]   datamem_rdata,
  input  logic          datamem_rvalid,
  output logic          arb_err
);

  dm_cmd_t              cmd [NUM_REQ];
  logic [NUM_REQ-1:0]   cmd_valid;
  logic [NUM_REQ-1:0]   eligible;
  dm_cmd_t              sel;
  logic                 sel_valid;
  req_id_t              gnt;
  req_id_t              last_served;
  req_id_t              lock_id;
  logic                 locked;
  logic                 stall;
  logic                 hs;
  logic                 tag_full;
  logic                 tag_empty;
  req_id_t              tag_head;
  logic                 tag_push;
  logic                 tag_pop;
  logic                 unused_addr_hi;

  // Gather both requesters into the common command format.
  always_comb begin
    cmd[0]       = '{addr: CMD_ADDR_W'(m0_cmd_addr), wdata: m0_cmd_wdata, mask: m0_cmd_mask, we: m0_cmd_we};
    cmd[1]       = '{addr: CMD_ADDR_W'(m1_cmd_addr), wdata: m1_cmd_wdata, mask: m1_cmd_mask, we: m1_cmd_we};
    cmd_valid    = {m1_cmd_valid, m0_cmd_valid};
    // A read that cannot get a tag slot does not compete, so a pending write can still go.
    eligible[0]  = m0_cmd_valid && (m0_cmd_we || !tag_full);
    eligible[1]  = m1_cmd_valid && (m1_cmd_we || !tag_full);
  end

  // Grant selection: a lock pins the requester, otherwise resolve ties by policy.
  always_comb begin
    gnt = 1'b0;
    if (locked) begin
      gnt = lock_id;
    end else if (eligible[0] && eligible[1]) begin
`ifdef DATAMEM_ARB_FIXED_PRIO_EN
      gnt = 1'b0;
`else
      gnt = ~last_served;
`endif
    end else if (eligible[1]) begin
      gnt = 1'b1;
    end
  end

  // Forward the granted command; reads are held back while every tag slot is in use.
  always_comb begin
    sel            = cmd[gnt];
    sel_valid      = cmd_valid[gnt];
    stall          = sel_valid && !sel.we && tag_full;
    datamem_valid  = sel_valid && !stall;
    datamem_addr   = sel.addr[AW-1:0];
    datamem_wdata  = sel.wdata;
    datamem_mask   = sel.mask;
    datamem_we     = sel.we;
    m0_cmd_ready   = datamem_ready && (gnt == 1'b0) && !stall;
    m1_cmd_ready   = datamem_ready && (gnt == 1'b1) && !stall;
    hs             = datamem_valid && datamem_ready;
    tag_push       = hs && !sel.we;
    tag_pop        = datamem_rvalid && !tag_empty;
    m0_rsp_valid   = tag_pop && (tag_head == 1'b0);
    m1_rsp_valid   = tag_pop && (tag_head == 1'b1);
    m0_rsp_data    = datamem_rdata;
    m1_rsp_data    = datamem_rdata;
    unused_addr_hi = ^sel.addr[CMD_ADDR_W-1:AW];
  end

  // Lock, round-robin history and the sticky orphan-response flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      locked      <= 1'b0;
      lock_id     <= 1'b0;
      last_served <= 1'b1;
      arb_err     <= 1'b0;
    end else begin
      if (datamem_valid && !datamem_ready) begin
        locked  <= 1'b1;
        lock_id <= gnt;
      end else if (hs) begin
        locked  <= 1'b0;
      end
      if (hs) last_served <= gnt;
      if (datamem_rvalid && tag_empty) arb_err <= 1'b1;
    end
  end

  arb_tag_fifo #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (tag_push),
    .push_id (gnt),
    .pop     (tag_pop),
    .full    (tag_full),
    .empty   (tag_empty),
    .head    (tag_head)
  );

endmodule
